// File: rtl/paddle_encoder.sv
// Per-player quadrature paddle input: synchronise, debounce, decode and keep a
// saturating position that is published to the renderer once per frame.
module paddle_encoder #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int STEP            = 4,
  parameter int POS_MIN         = 0,
  parameter int POS_MAX         = 420,
  parameter int POS_RESET       = 210
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       vsync,
  output logic [9:0] move,
  output logic       error
);

  localparam logic [10:0] DEB_LAST  = 11'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] STEP11    = 11'(STEP);
  localparam logic [10:0] MAX11     = 11'(POS_MAX);
  localparam logic [10:0] DEC_FLOOR = 11'(POS_MIN + STEP);
  localparam logic [9:0]  MIN10     = 10'(POS_MIN);
  localparam logic [9:0]  MAX10     = 10'(POS_MAX);
  localparam logic [9:0]  RESET10   = 10'(POS_RESET);

  logic        a_meta_q, a_meta_d, a_sync_q, a_sync_d;
  logic        b_meta_q, b_meta_d, b_sync_q, b_sync_d;
  logic [10:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic        stable_a_q, stable_a_d, stable_b_q, stable_b_d;
  logic [1:0]  prev_q, prev_d;
  logic [9:0]  pos_q, pos_d;
  logic        vsync_dly_q, vsync_dly_d;
  logic [9:0]  move_q, move_d;
  logic        error_q, error_d;

  logic [1:0]  cur;
  logic        step_inc, step_dec, step_bad;
  logic [10:0] pos_ext, pos_sum;

  always_comb begin
    a_meta_d    = a;
    a_sync_d    = a_meta_q;
    b_meta_d    = b;
    b_sync_d    = b_meta_q;

    // Any sample matching the stable value restarts the count, so a glitch
    // must persist for the full window to be accepted.
    stable_a_d  = stable_a_q;
    cnt_a_d     = '0;
    if (a_sync_q != stable_a_q) begin
      if (cnt_a_q == DEB_LAST) begin
        stable_a_d = a_sync_q;
      end else begin
        cnt_a_d = cnt_a_q + 11'd1;
      end
    end

    stable_b_d  = stable_b_q;
    cnt_b_d     = '0;
    if (b_sync_q != stable_b_q) begin
      if (cnt_b_q == DEB_LAST) begin
        stable_b_d = b_sync_q;
      end else begin
        cnt_b_d = cnt_b_q + 11'd1;
      end
    end

    cur      = {stable_a_q, stable_b_q};
    prev_d   = cur;
    step_inc = 1'b0;
    step_dec = 1'b0;
    step_bad = 1'b0;
    case ({prev_q, cur})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: step_inc = 1'b1;
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: step_dec = 1'b1;
      4'b11_00, 4'b00_11, 4'b10_01, 4'b01_10: step_bad = 1'b1;
      default: ;
    endcase

    // 11-bit arithmetic keeps the clamp comparisons free of wraparound.
    pos_ext = {1'b0, pos_q};
    pos_sum = pos_ext + STEP11;
    pos_d   = pos_q;
    if (step_inc) begin
      pos_d = (pos_sum > MAX11) ? MAX10 : pos_sum[9:0];
    end else if (step_dec) begin
      pos_d = (pos_ext < DEC_FLOOR) ? MIN10 : (pos_q - STEP11[9:0]);
    end
    error_d = step_bad;

    // Publishing the pre-update pos keeps move consistent within a frame.
    vsync_dly_d = vsync;
    move_d      = (vsync && !vsync_dly_q) ? pos_q : move_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta_q    <= 1'b1;
      a_sync_q    <= 1'b1;
      b_meta_q    <= 1'b1;
      b_sync_q    <= 1'b1;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      stable_a_q  <= 1'b1;
      stable_b_q  <= 1'b1;
      prev_q      <= 2'b11;
      pos_q       <= RESET10;
      vsync_dly_q <= 1'b0;
      move_q      <= RESET10;
      error_q     <= 1'b0;
    end else begin
      a_meta_q    <= a_meta_d;
      a_sync_q    <= a_sync_d;
      b_meta_q    <= b_meta_d;
      b_sync_q    <= b_sync_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      stable_a_q  <= stable_a_d;
      stable_b_q  <= stable_b_d;
      prev_q      <= prev_d;
      pos_q       <= pos_d;
      vsync_dly_q <= vsync_dly_d;
      move_q      <= move_d;
      error_q     <= error_d;
    end
  end

  assign move  = move_q;
  assign error = error_q;

endmodule

// File: tb/tb_paddle_encoder.sv
// Directed bench for paddle_encoder: three instances (mid, low and high start
// positions) share the encoder pins and are checked against a position model.
module tb_paddle_encoder;

  logic       clk = 1'b0;
  logic       reset, a, b, vsync;
  logic [9:0] move0, move1, move2;
  logic       error0, error1, error2;

  int checks = 0;
  int errors = 0;
  int exp0, exp1, exp2;
  int err_cnt0 = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  paddle_encoder #(.DEBOUNCE_CYCLES(4), .POS_RESET(210)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .vsync(vsync), .move(move0), .error(error0));
  paddle_encoder #(.DEBOUNCE_CYCLES(4), .POS_RESET(2)) dut_lo (
    .clk(clk), .reset(reset), .a(a), .b(b), .vsync(vsync), .move(move1), .error(error1));
  paddle_encoder #(.DEBOUNCE_CYCLES(4), .POS_RESET(418)) dut_hi (
    .clk(clk), .reset(reset), .a(a), .b(b), .vsync(vsync), .move(move2), .error(error2));

  // error is registered, so sampling on the falling edge counts each high cycle once
  always @(negedge clk) if (error0 === 1'b1) err_cnt0++;

  function automatic int model_step(input int p, input int dir);
    if (dir > 0) return (p + 4 > 420) ? 420 : p + 4;
    if (dir < 0) return (p < 4) ? 0 : p - 4;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new pin state, hold long enough to pass sync + debounce + decode.
  task automatic drive_ab(input logic na, input logic nb, input int dir, input string tag);
    a = na;
    b = nb;
    tick(10);
    exp0 = model_step(exp0, dir);
    exp1 = model_step(exp1, dir);
    exp2 = model_step(exp2, dir);
    check({tag, "_pos_mid"}, 32'(dut.pos_q), 32'(exp0));
    check({tag, "_pos_lo"},  32'(dut_lo.pos_q), 32'(exp1));
    check({tag, "_pos_hi"},  32'(dut_hi.pos_q), 32'(exp2));
  endtask

  task automatic vsync_pulse(input logic [9:0] old_move, input string tag);
    vsync = 1'b1;
    exp_q.push_back(10'(exp0));
    check({tag, "_move_before_edge"}, 32'(move0), 32'(old_move));
    tick(1);
    check({tag, "_move"}, 32'(move0), 32'(exp_q.pop_front()));
    tick(3);
    check({tag, "_move_level_hold"}, 32'(move0), 32'(exp0));
    vsync = 1'b0;
    tick(2);
  endtask

  initial begin
    int e;
    reset = 1'b1; a = 1'b1; b = 1'b1; vsync = 1'b0;
    tick(2);
    check("reset_move", 32'(move0), 32'd210);
    check("reset_error", 32'(error0), 32'd0);
    reset = 1'b0;
    tick(1);
    exp0 = 210; exp1 = 2; exp2 = 418;
    check("reset_pos_mid", 32'(dut.pos_q), 32'd210);
    check("reset_pos_lo", 32'(dut_lo.pos_q), 32'd2);
    check("reset_pos_hi", 32'(dut_hi.pos_q), 32'd418);

    // increment sequence 11->10->00->01->11
    drive_ab(1'b1, 1'b0, 1, "inc1");
    drive_ab(1'b0, 1'b0, 1, "inc2");
    drive_ab(1'b0, 1'b1, 1, "inc3");
    drive_ab(1'b1, 1'b1, 1, "inc4");
    check("inc_total_mid", 32'(dut.pos_q), 32'd226);
    check("inc_sat_hi", 32'(dut_hi.pos_q), 32'd420);
    vsync_pulse(10'd210, "frame1");
    check("frame1_move_lo", 32'(move1), 32'(exp1));
    check("frame1_move_hi", 32'(move2), 32'd420);

    // two decrement sequences drive dut_lo into the floor
    for (int k = 0; k < 2; k++) begin
      drive_ab(1'b0, 1'b1, -1, "dec1");
      drive_ab(1'b0, 1'b0, -1, "dec2");
      drive_ab(1'b1, 1'b0, -1, "dec3");
      drive_ab(1'b1, 1'b1, -1, "dec4");
    end
    check("dec_floor_lo", 32'(dut_lo.pos_q), 32'd0);
    check("err_none_yet", 32'(err_cnt0), 32'd0);

    // glitch of 3 cycles is rejected
    a = 1'b0; tick(3); a = 1'b1; tick(10);
    check("glitch_pos", 32'(dut.pos_q), 32'(exp0));
    check("glitch_err", 32'(err_cnt0), 32'd0);
    drive_ab(1'b0, 1'b1, -1, "long_glitch_dn");
    drive_ab(1'b1, 1'b1, 1, "long_glitch_up");
    check("long_glitch_net", 32'(dut.pos_q), 32'd194);

    // illegal double-bit transitions
    e = err_cnt0;
    drive_ab(1'b0, 1'b0, 0, "illegal_down");
    check("illegal_err_pulse", 32'(err_cnt0), 32'(e + 1));
    check("illegal_prev", 32'(dut.prev_q), 32'd0);
    drive_ab(1'b1, 1'b1, 0, "illegal_up");
    check("illegal_err_pulse2", 32'(err_cnt0), 32'(e + 2));
    check("illegal_prev2", 32'(dut.prev_q), 32'd3);

    // pos update lands on the same edge as the vsync rise
    b = 1'b0;
    tick(6);
    vsync = 1'b1;
    exp_q.push_back(10'(exp0));
    tick(1);
    exp0 = model_step(exp0, 1);
    exp1 = model_step(exp1, 1);
    exp2 = model_step(exp2, 1);
    check("race_move_old", 32'(move0), 32'(exp_q.pop_front()));
    check("race_pos_new", 32'(dut.pos_q), 32'(exp0));
    tick(3);
    vsync = 1'b0;
    tick(3);
    check("race_move_held", 32'(move0), 32'd194);
    vsync_pulse(10'd194, "frame_next");
    drive_ab(1'b1, 1'b1, -1, "race_restore");

    // reset while a change is part-way through debounce
    e = err_cnt0;
    a = 1'b0;
    tick(4);
    reset = 1'b1; a = 1'b1;
    tick(1);
    reset = 1'b0;
    exp0 = 210; exp1 = 2; exp2 = 418;
    check("midrst_pos", 32'(dut.pos_q), 32'd210);
    check("midrst_move", 32'(move0), 32'd210);
    check("midrst_cnt", 32'(dut.cnt_a_q), 32'd0);
    tick(12);
    check("midrst_pos_after", 32'(dut.pos_q), 32'(exp0));
    check("midrst_pos_lo_after", 32'(dut_lo.pos_q), 32'(exp1));
    check("midrst_no_err", 32'(err_cnt0), 32'(e));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
